// File: rtl/univ_counter_seq_ctrl.sv
// Control sequencer for the N-bit universal binary counter: start/stop/clear, prescaled stepping,
// and up-wrap / down-wrap / ping-pong / one-shot run modes. Ping-pong is built only when
// CNT_SEQ_PINGPONG_EN is defined; otherwise mode 10 runs as up-wrap.
module univ_counter_seq_ctrl #(
  parameter int unsigned N   = 8,
  parameter int unsigned P_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           stop,
  input  logic           clr,
  input  logic [1:0]     mode,
  input  logic [P_W-1:0] div,
  input  logic [N-1:0]   preset,
  input  logic           max_tick,
  input  logic           min_tick,
  output logic           syn_clr,
  output logic           load,
  output logic           en,
  output logic           up,
  output logic [N-1:0]   d,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [P_W-1:0] presc_q, presc_d;
  logic [P_W-1:0] div_q, div_d;
  logic [1:0]     mode_q, mode_d;
  logic [N-1:0]   d_q, d_d;
  logic           up_q, up_d;
  logic           step;
  logic           flip;

`ifdef CNT_SEQ_PINGPONG_EN
  // Reverse at the boundary in the same cycle so the end value is never repeated or wrapped.
  assign flip = (mode_q == 2'b10) & ((up_q & max_tick) | (~up_q & min_tick));
`else
  logic unused_min_tick;
  assign unused_min_tick = min_tick;
  assign flip = 1'b0;
`endif

  assign step = (presc_q == div_q);
  assign busy = (state_q == StLoad) || (state_q == StRun);
  assign done = (state_q == StDone);
  assign d    = d_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    mode_d  = mode_q;
    d_d     = d_q;
    up_d    = up_q;
    syn_clr = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    up      = up_q;

    if (clr) begin
      syn_clr = 1'b1;
      state_d = StIdle;
      presc_d = '0;
      up_d    = 1'b1;
    end else if (stop && busy) begin
      state_d = StIdle;
      presc_d = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (state_q == StDone) state_d = StIdle;
          if (start) begin
            mode_d  = mode;
            div_d   = div;
            d_d     = preset;
            state_d = StLoad;
          end
        end
        StLoad: begin
          load    = 1'b1;
          presc_d = '0;
          up_d    = (mode_q != 2'b01);
          state_d = StRun;
        end
        StRun: begin
          if (step) begin
            presc_d = '0;
            if (mode_q == 2'b11) begin
              if (max_tick) begin
                state_d = StDone;
              end else begin
                en = 1'b1;
                up = 1'b1;
              end
            end else begin
              en   = 1'b1;
              up   = up_q ^ flip;
              up_d = up_q ^ flip;
            end
          end else begin
            presc_d = presc_q + {{(P_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      div_q   <= '0;
      mode_q  <= 2'b00;
      d_q     <= '0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      d_q     <= d_d;
      up_q    <= up_d;
    end
  end

endmodule

// File: tb/tb_univ_counter_seq_ctrl.sv
// Bench for univ_counter_seq_ctrl driving a behavioural universal counter: vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_univ_counter_seq_ctrl;
  localparam int N   = 8;
  localparam int P_W = 16;
`ifdef CNT_SEQ_PINGPONG_EN
  localparam bit PingPong = 1'b1;
`else
  localparam bit PingPong = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [P_W-1:0] div = '0;
  logic [N-1:0] preset = '0;
  logic max_tick, min_tick, syn_clr, load, en, up, busy, done;
  logic [N-1:0] d, q;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  univ_counter_seq_ctrl #(.N(N), .P_W(P_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clr(clr), .mode(mode),
    .div(div), .preset(preset), .max_tick(max_tick), .min_tick(min_tick), .syn_clr(syn_clr),
    .load(load), .en(en), .up(up), .d(d), .busy(busy), .done(done)
  );

  // Downstream universal counter
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (syn_clr) q <= '0;
    else if (load) q <= d;
    else if (en) q <= up ? q + 8'd1 : q - 8'd1;
  end
  assign max_tick = (q == {N{1'b1}});
  assign min_tick = (q == '0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic st, sp, cl; logic [1:0] md; logic [15:0] dv; logic [7:0] pr;
    logic e_sc, e_ld, e_en, e_up, e_busy, e_done; logic [7:0] e_q;
  } vec_t;
  vec_t vt[21];

  // Reference model state
  int ph;  // 0 idle, 1 load, 2 run, 3 done
  logic [1:0] m_mode;
  int m_div, m_run;
  logic [7:0] m_d, m_q;
  logic m_dir;

  initial begin
    int en_cnt, done_cnt, busy_at_done, got;
    //         st sp cl md  dv     pr     sc ld en up bs dn q
    vt[0]  = '{1, 0, 0, 0, 16'd0, 8'hFD, 0, 0, 0, 1, 0, 0, 8'h00};
    vt[1]  = '{0, 0, 0, 0, 16'd0, 8'hFD, 0, 1, 0, 1, 1, 0, 8'h00};
    vt[2]  = '{0, 0, 0, 0, 16'd0, 8'hFD, 0, 0, 1, 1, 1, 0, 8'hFD};
    vt[3]  = '{0, 0, 0, 0, 16'd0, 8'hFD, 0, 0, 1, 1, 1, 0, 8'hFE};
    vt[4]  = '{0, 0, 0, 0, 16'd0, 8'hFD, 0, 0, 1, 1, 1, 0, 8'hFF};
    vt[5]  = '{0, 0, 0, 0, 16'd0, 8'hFD, 0, 0, 1, 1, 1, 0, 8'h00};
    vt[6]  = '{0, 1, 0, 0, 16'd0, 8'hFD, 0, 0, 0, 1, 1, 0, 8'h01};
    vt[7]  = '{0, 0, 0, 0, 16'd0, 8'hFD, 0, 0, 0, 1, 0, 0, 8'h01};
    vt[8]  = '{1, 0, 0, 1, 16'd3, 8'h05, 0, 0, 0, 1, 0, 0, 8'h01};
    vt[9]  = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 1, 0, 1, 1, 0, 8'h01};
    vt[10] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 0, 0, 1, 0, 8'h05};
    vt[11] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 0, 0, 1, 0, 8'h05};
    vt[12] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 0, 0, 1, 0, 8'h05};
    vt[13] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 1, 0, 1, 0, 8'h05};
    vt[14] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 0, 0, 1, 0, 8'h04};
    vt[15] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 0, 0, 1, 0, 8'h04};
    vt[16] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 0, 0, 1, 0, 8'h04};
    vt[17] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 1, 0, 1, 0, 8'h04};
    vt[18] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 0, 0, 1, 0, 8'h03};
    vt[19] = '{0, 1, 1, 0, 16'd0, 8'hAA, 1, 0, 0, 0, 1, 0, 8'h03};
    vt[20] = '{0, 0, 0, 0, 16'd0, 8'hAA, 0, 0, 0, 1, 0, 0, 8'h00};

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset syn_clr", syn_clr, 0); chk("reset load", load, 0); chk("reset en", en, 0);
    chk("reset up", up, 1); chk("reset busy", busy, 0); chk("reset done", done, 0);
    chk("reset d", d, 0); chk("reset q", q, 0);

    for (int i = 0; i < 21; i++) begin
      nxt();
      start = vt[i].st; stop = vt[i].sp; clr = vt[i].cl;
      mode = vt[i].md; div = vt[i].dv; preset = vt[i].pr;
      #1;
      chk($sformatf("vec%0d syn_clr", i), syn_clr, vt[i].e_sc);
      chk($sformatf("vec%0d load", i), load, vt[i].e_ld);
      chk($sformatf("vec%0d en", i), en, vt[i].e_en);
      chk($sformatf("vec%0d up", i), up, vt[i].e_up);
      chk($sformatf("vec%0d busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d done", i), done, vt[i].e_done);
      chk($sformatf("vec%0d q", i), q, vt[i].e_q);
    end

    // One-shot: FD, FE, FF then done with no further steps
    nxt(); start = 1; stop = 0; clr = 0; mode = 2'b11; div = 16'd1; preset = 8'hFD;
    nxt(); start = 0;
    en_cnt = 0; done_cnt = 0; busy_at_done = 1;
    for (int c = 0; c < 20; c++) begin
      nxt();
      if (en) en_cnt++;
      if (done) begin done_cnt++; busy_at_done = busy; end
    end
    chk("oneshot en count", en_cnt, 2);
    chk("oneshot done pulses", done_cnt, 1);
    chk("oneshot busy at done", busy_at_done, 0);
    chk("oneshot q held", q, 8'hFF);
    chk("oneshot busy after", busy, 0);

    // Ping-pong at the top boundary, then bounce at zero
    nxt(); start = 1; mode = 2'b10; div = 16'd0; preset = 8'hFE;
    nxt(); start = 0;
    nxt(); chk("pp q1", q, 8'hFE); chk("pp en1", en, 1); chk("pp up1", up, 1);
    nxt(); chk("pp q2", q, 8'hFF); chk("pp en2", en, 1); chk("pp up2", up, PingPong ? 0 : 1);
    nxt(); chk("pp q3", q, PingPong ? 8'hFE : 8'h00);
    nxt(); chk("pp q4", q, PingPong ? 8'hFD : 8'h01);
    if (PingPong) begin
      got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
        nxt();
        if (q == 8'h00) got = 1;
      end
      chk("pp reached zero", got, 1);
      chk("pp up at zero", up, 1);
      chk("pp en at zero", en, 1);
      nxt(); chk("pp q after zero", q, 8'h01);
    end
    clr = 1; nxt(); clr = 0;

    // Asynchronous reset mid-run, between clock edges
    nxt(); start = 1; mode = 2'b01; div = 16'd0; preset = 8'h10;
    nxt(); start = 0;
    repeat (3) nxt();
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async syn_clr", syn_clr, 0); chk("async load", load, 0); chk("async en", en, 0);
    chk("async up", up, 1); chk("async busy", busy, 0); chk("async done", done, 0);
    chk("async d", d, 0); chk("async q", q, 0);
    @(negedge clk); reset_n = 1'b1;

    // Randomized run against the reference model
    ph = 0; m_mode = 0; m_div = 0; m_run = 0; m_d = 0; m_q = 0; m_dir = 1;
    for (int c = 0; c < 3000; c++) begin
      logic st, sp, cl, e_sc, e_ld, e_en, e_up, e_busy, e_done, n_dir;
      logic [1:0] md;
      logic [15:0] dv;
      logic [7:0] pr, nq;
      int nph, n_run, eff;
      nxt();
      st = ($urandom % 6) == 0; sp = ($urandom % 40) == 0; cl = ($urandom % 60) == 0;
      md = 2'($urandom); dv = 16'($urandom % 4);
      pr = ($urandom % 2) ? 8'(8'hF8 + $urandom % 8) : 8'($urandom);
      start = st; stop = sp; clr = cl; mode = md; div = dv; preset = pr;
      #1;
      e_sc = 0; e_ld = 0; e_en = 0; e_up = m_dir;
      e_busy = (ph == 1 || ph == 2); e_done = (ph == 3);
      nph = ph; nq = m_q; n_dir = m_dir; n_run = m_run;
      if (cl) begin
        e_sc = 1; nph = 0; n_dir = 1; nq = 0;
      end else if (sp && e_busy) begin
        nph = 0;
      end else if (ph == 0 || ph == 3) begin
        if (ph == 3) nph = 0;
        if (st) nph = 1;
      end else if (ph == 1) begin
        e_ld = 1; nq = m_d; n_run = 0; n_dir = (m_mode != 2'b01); nph = 2;
      end else begin
        n_run = m_run + 1;
        if (n_run % (m_div + 1) == 0) begin
          eff = (m_mode == 2'b10 && !PingPong) ? 0 : int'(m_mode);
          if (eff == 3) begin
            if (m_q == 8'hFF) nph = 3;
            else begin e_en = 1; e_up = 1; nq = m_q + 8'd1; end
          end else begin
            if (eff == 2 && ((m_dir && m_q == 8'hFF) || (!m_dir && m_q == 8'h00))) n_dir = !m_dir;
            e_en = 1; e_up = n_dir;
            nq = n_dir ? m_q + 8'd1 : m_q - 8'd1;
          end
        end
      end
      chk("rnd syn_clr", syn_clr, e_sc); chk("rnd load", load, e_ld);
      chk("rnd en", en, e_en); chk("rnd up", up, e_up);
      chk("rnd busy", busy, e_busy); chk("rnd done", done, e_done);
      chk("rnd d", d, m_d); chk("rnd q", q, m_q);
      if (!cl && !(sp && e_busy) && (ph == 0 || ph == 3) && st) begin
        m_mode = md; m_div = int'(dv); m_d = pr;
      end
      ph = nph; m_q = nq; m_dir = n_dir; m_run = n_run;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
